// File: rtl/hi_lo_pkg.sv
// Shared definitions for the HI/LO unit: opcodes, FSM state type and op-class decode helpers.
package hi_lo_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hi_lo_state_t;

  function automatic logic is_hi_lo_op(input logic [5:0] op);
    return op inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_long_op(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_read_op(input logic [5:0] op);
    return op inside {OP_MFHI, OP_MFLO};
  endfunction

endpackage

// File: rtl/hi_lo_if.sv
// Pipeline-to-HI/LO-unit bundle: instruction/ALU result inputs and read/busy/stall responses.
interface hi_lo_if;
  logic        op_valid;
  logic [5:0]  ALU_operation;
  logic [31:0] ALU_HI_output;
  logic [31:0] ALU_LO_output;
  logic [31:0] hi_lo_read_data;
  logic        busy;
  logic        stall;

  modport master (
    output op_valid, ALU_operation, ALU_HI_output, ALU_LO_output,
    input  hi_lo_read_data, busy, stall
  );

  modport slave (
    input  op_valid, ALU_operation, ALU_HI_output, ALU_LO_output,
    output hi_lo_read_data, busy, stall
  );
endinterface

// File: rtl/hi_lo_countdown.sv
// Loadable down-counter timing the MULT/DIV latency; stops at zero, flags the final count of one.
module hi_lo_countdown #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign value = count_q;
  assign last  = (count_q == WIDTH'(1));

endmodule

// File: rtl/hi_lo_unit.sv
// Architectural HI/LO registers with modelled MULT/DIV latency and pipeline stall generation.
// Optional build macro HI_LO_FWD_EN lets MFHI/MFLO read the pending result in the last BUSY cycle.
module hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input logic   clk,
  input logic   reset_n,
  hi_lo_if.slave bus
);

  localparam int MAX_LATENCY = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

  hi_lo_state_t state_q, state_d;

  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic [CNT_W-1:0] count;
  logic             cnt_last;

  logic       accept;
  logic       commit;
  logic       stall;
  logic       read_fwd;
  logic       hl_op;
  logic [5:0] op;

  assign op    = bus.ALU_operation;
  assign hl_op = bus.op_valid && is_hi_lo_op(op);

  hi_lo_countdown #(
    .WIDTH(CNT_W)
  ) u_countdown (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .en        (state_q == BUSY),
    .value     (count),
    .last      (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    accept         = 1'b0;
    commit         = 1'b0;
    stall          = 1'b0;
    read_fwd       = 1'b0;

    case (state_q)
      IDLE: begin
        accept = hl_op;
        if (hl_op && is_long_op(op)) begin
          cnt_load       = 1'b1;
          cnt_load_value = is_div_op(op) ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY);
          state_d        = BUSY;
        end
      end

      BUSY: begin
        stall = hl_op;
`ifdef HI_LO_FWD_EN
        // The pending result is final in the last cycle, so reads can be served from it.
        if (cnt_last && hl_op && is_read_op(op)) begin
          stall    = 1'b0;
          read_fwd = 1'b1;
        end
`endif
        if (cnt_last) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the values present before the edge.
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end else if (accept && (op == OP_MTHI)) begin
        hi_q <= bus.ALU_HI_output;
      end else if (accept && (op == OP_MTLO)) begin
        lo_q <= bus.ALU_LO_output;
      end

      // ALU results are captured verbatim; this unit performs no arithmetic.
      if (cnt_load) begin
        pend_hi_q <= bus.ALU_HI_output;
        pend_lo_q <= bus.ALU_LO_output;
      end
    end
  end

  always_comb begin
    bus.hi_lo_read_data = '0;
    if (bus.op_valid && (op == OP_MFHI)) begin
      bus.hi_lo_read_data = read_fwd ? pend_hi_q : hi_q;
    end else if (bus.op_valid && (op == OP_MFLO)) begin
      bus.hi_lo_read_data = read_fwd ? pend_lo_q : lo_q;
    end
  end

  assign bus.busy  = (state_q == BUSY);
  assign bus.stall = stall;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Self-checking bench for hi_lo_unit: per-cycle reference model plus directed literal checks.
module tb_hi_lo_unit;

  localparam int ML = 4;
  localparam int DL = 32;

  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MTHI  = 6'b010001;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_MTLO  = 6'b010011;
  localparam logic [5:0] C_MULT  = 6'b011000;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIV   = 6'b011010;
  localparam logic [5:0] C_DIVU  = 6'b011011;
  localparam logic [5:0] C_ADDU  = 6'b100001;

`ifdef HI_LO_FWD_EN
  localparam bit   FWD            = 1'b1;
  localparam int   MFLO_STALLS    = 3;
  localparam logic L1_READ_STALL  = 1'b0;
`else
  localparam bit   FWD            = 1'b0;
  localparam int   MFLO_STALLS    = 4;
  localparam logic L1_READ_STALL  = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hi_lo_if bus ();
  hi_lo_if bus1 ();

  assign bus1.op_valid      = bus.op_valid;
  assign bus1.ALU_operation = bus.ALU_operation;
  assign bus1.ALU_HI_output = bus.ALU_HI_output;
  assign bus1.ALU_LO_output = bus.ALU_LO_output;

  hi_lo_unit #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  hi_lo_unit #(.MULT_LATENCY(1), .DIV_LATENCY(2)) dut_l1 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural HI/LO plus at most one pending result tagged with its commit edge.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_valid;
  int          p_at;
  int          cyc;

  initial begin : model
    logic        last, hl, rd_hi, rd_lo, e_stall;
    logic [31:0] e_read;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 0; p_at = 0; cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 0;
      end else if (p_valid) begin
        if (cyc == p_at) begin
          m_hi = p_hi; m_lo = p_lo; p_valid = 0;
        end
      end else if (bus.op_valid) begin
        case (bus.ALU_operation)
          C_MULT, C_MULTU: begin
            p_valid = 1; p_hi = bus.ALU_HI_output; p_lo = bus.ALU_LO_output; p_at = cyc + ML;
          end
          C_DIV, C_DIVU: begin
            p_valid = 1; p_hi = bus.ALU_HI_output; p_lo = bus.ALU_LO_output; p_at = cyc + DL;
          end
          C_MTHI:  m_hi = bus.ALU_HI_output;
          C_MTLO:  m_lo = bus.ALU_LO_output;
          default: ;
        endcase
      end

      @(negedge clk);
      last  = p_valid && (p_at == cyc + 1);
      hl    = bus.op_valid && (bus.ALU_operation inside {C_MFHI, C_MTHI, C_MFLO, C_MTLO,
                                                          C_MULT, C_MULTU, C_DIV, C_DIVU});
      rd_hi = bus.op_valid && (bus.ALU_operation == C_MFHI);
      rd_lo = bus.op_valid && (bus.ALU_operation == C_MFLO);
      e_stall = hl && p_valid && !(FWD && last && (rd_hi || rd_lo));
      e_read  = rd_hi ? ((FWD && last) ? p_hi : m_hi) :
                rd_lo ? ((FWD && last) ? p_lo : m_lo) : 32'h0;
      check("model_busy", {31'b0, bus.busy}, {31'b0, p_valid});
      check("model_stall", {31'b0, bus.stall}, {31'b0, e_stall});
      if (!e_stall) check("model_read", bus.hi_lo_read_data, e_read);
    end
  end

  task automatic present(input logic v, input logic [5:0] op,
                         input logic [31:0] hi, input logic [31:0] lo);
    bus.op_valid      = v;
    bus.ALU_operation = op;
    bus.ALU_HI_output = hi;
    bus.ALU_LO_output = lo;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    reset_n = 1'b0;
    present(1'b0, 6'h0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // Reset state
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_stall", {31'b0, bus.stall}, 32'h0);
    check("reset_mfhi", bus.hi_lo_read_data, 32'h0);

    // Reset in the middle of a DIVU
    present(1'b1, C_MTHI, 32'h0BAD_F00D, 32'h0);
    next_cycle();
    present(1'b1, C_DIVU, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    next_cycle();
    present(1'b0, 6'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_div_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_div_mfhi", bus.hi_lo_read_data, 32'h0);
    next_cycle();
    present(1'b1, C_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_div_mflo", bus.hi_lo_read_data, 32'h0);
    next_cycle();

    // MTHI then MFHI / MFLO
    present(1'b1, C_MTHI, 32'hDEAD_BEEF, 32'h5555_5555);
    next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("mthi_read", bus.hi_lo_read_data, 32'hDEAD_BEEF);
    check("mthi_stall", {31'b0, bus.stall}, 32'h0);
    next_cycle();
    present(1'b1, C_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mthi_lo_kept", bus.hi_lo_read_data, 32'h0);
    next_cycle();

    // MULT followed by MFLO every cycle
    present(1'b1, C_MULT, 32'h0000_0001, 32'h8000_0000);
    next_cycle();
    present(1'b1, C_MFLO, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      next_cycle();
    end
    check("mult_stalls", n, MFLO_STALLS);
    check("mult_lo", bus.hi_lo_read_data, 32'h8000_0000);
    next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("mult_hi", bus.hi_lo_read_data, 32'h0000_0001);
    next_cycle();

    // DIV busy window length
    present(1'b1, C_DIV, 32'h0000_0007, 32'h0000_0003);
    next_cycle();
    present(1'b0, 6'h0, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      next_cycle();
    end
    check("div_busy_len", n, DL);
    next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("div_hi", bus.hi_lo_read_data, 32'h0000_0007);
    next_cycle();
    present(1'b1, C_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("div_lo", bus.hi_lo_read_data, 32'h0000_0003);
    next_cycle();

    // MTLO held off by BUSY, then overwrites the committed LO
    present(1'b1, C_MULTU, 32'h0000_0011, 32'h0000_0022);
    next_cycle();
    present(1'b1, C_MTLO, 32'hFFFF_FFFF, 32'h1234_5678);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      next_cycle();
    end
    check("mtlo_stalls", n, ML);
    next_cycle();
    present(1'b1, C_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mtlo_lo", bus.hi_lo_read_data, 32'h1234_5678);
    next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("mtlo_hi_kept", bus.hi_lo_read_data, 32'h0000_0011);
    next_cycle();

    // ADDU never stalls; DIVU right after a MULT commit is accepted with no gap
    present(1'b1, C_MULT, 32'h0000_CAFE, 32'h0000_F00D);
    next_cycle();
    for (int i = 0; i < ML; i++) begin
      present(1'b1, C_ADDU, 32'h1, 32'h2);
      @(negedge clk);
      check("addu_stall", {31'b0, bus.stall}, 32'h0);
      check("addu_busy", {31'b0, bus.busy}, 32'h1);
      next_cycle();
    end
    present(1'b1, C_DIVU, 32'h0000_0009, 32'h0000_0008);
    @(negedge clk);
    check("b2b_busy", {31'b0, bus.busy}, 32'h0);
    check("b2b_stall", {31'b0, bus.stall}, 32'h0);
    next_cycle();
    present(1'b0, 6'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b_accepted", {31'b0, bus.busy}, 32'h1);
    for (int i = 0; i < 100 && bus.busy; i++) next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b_hi", bus.hi_lo_read_data, 32'h0000_0009);
    next_cycle();

    // Latency of one on the second instance
    reset_n = 1'b0;
    present(1'b0, 6'h0, 32'h0, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    present(1'b1, C_MULT, 32'h0000_0003, 32'h0000_0004);
    next_cycle();
    present(1'b1, C_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("l1_busy", {31'b0, bus1.busy}, 32'h1);
    check("l1_stall", {31'b0, bus1.stall}, {31'b0, L1_READ_STALL});
    next_cycle();
    @(negedge clk);
    check("l1_idle", {31'b0, bus1.busy}, 32'h0);
    check("l1_hi", bus1.hi_lo_read_data, 32'h0000_0003);
    next_cycle();
    present(1'b0, 6'h0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
